// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: MUL_LATENCY-cycle multiply class, 34-cycle restoring divide.
// Optional macro DIV_EARLY_OUT_EN: divides with |divisor| > |dividend| finish in 2 busy cycles.
module hilo_muldiv_sequencer #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_BITS    = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic [63:0] i_hilo_in,
  input  logic        i_read_hilo,
  input  logic        i_cancel,
  output logic        o_busy,
  output logic        o_stall_req,
  output logic        o_hilo_write,
  output logic [31:0] o_hi_out,
  output logic [31:0] o_lo_out
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DIV_FIX, S_DONE} state_t;

  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;

  state_t      r_state;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_hilo;
  logic [5:0]  r_cnt;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic        r_q_neg;
  logic        r_r_neg;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_is_div;
  logic        w_sdiv;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_early;
  logic        w_mul_signed;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic [63:0] w_mul_res;
  logic [32:0] w_partial;
  logic [32:0] w_diff;
  logic        w_q_bit;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign o_busy       = (r_state != S_IDLE);
  assign o_stall_req  = o_busy & (i_start | i_read_hilo);
  assign o_hilo_write = (r_state == S_DONE) & ~i_cancel;
  assign o_hi_out     = r_hi;
  assign o_lo_out     = r_lo;

  assign w_accept = i_start & ~i_cancel & (r_state == S_IDLE) & (i_op <= OP_MSUB);
  assign w_is_div = (i_op == OP_DIV) | (i_op == OP_DIVU);
  assign w_sdiv   = (i_op == OP_DIV);
  assign w_a_mag  = (w_sdiv & i_op_a[31]) ? (32'd0 - i_op_a) : i_op_a;
  assign w_b_mag  = (w_sdiv & i_op_b[31]) ? (32'd0 - i_op_b) : i_op_b;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (w_b_mag != 32'd0) & (w_b_mag > w_a_mag);
`else
  assign w_early = 1'b0;
`endif

  // Sign/zero extension to 64 bits makes the truncated product correct for both signednesses.
  assign w_mul_signed = (r_op != OP_MULTU);
  assign w_a_ext      = {{32{w_mul_signed & r_a[31]}}, r_a};
  assign w_b_ext      = {{32{w_mul_signed & r_b[31]}}, r_b};
  assign w_prod       = w_a_ext * w_b_ext;

  always_comb begin
    w_mul_res = w_prod;
    if (r_op == OP_MADD) w_mul_res = r_hilo + w_prod;
    else if (r_op == OP_MSUB) w_mul_res = r_hilo - w_prod;
  end

  // One restoring step: the dividend shifts out of r_quo MSB-first while quotient bits shift in.
  assign w_partial  = {r_rem, r_quo[31]};
  assign w_diff     = w_partial - {1'b0, r_dvs};
  assign w_q_bit    = ~w_diff[32];
  assign w_rem_next = w_q_bit ? w_diff[31:0] : w_partial[31:0];

  assign w_quo_fix = r_q_neg ? (32'd0 - r_quo) : r_quo;
  assign w_rem_fix = r_r_neg ? (32'd0 - r_rem) : r_rem;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hilo  <= '0;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= i_op;
            r_a    <= i_op_a;
            r_b    <= i_op_b;
            r_hilo <= i_hilo_in;
            if (w_is_div) begin
              r_dvs   <= w_b_mag;
              r_q_neg <= w_sdiv & (i_op_a[31] ^ i_op_b[31]);
              r_r_neg <= w_sdiv & i_op_a[31];
              r_cnt   <= 6'(DIV_BITS - 1);
              if (w_early) begin
                r_quo   <= '0;
                r_rem   <= w_a_mag;
                r_state <= S_DIV_FIX;
              end else begin
                r_quo   <= w_a_mag;
                r_rem   <= '0;
                r_state <= S_DIV;
              end
            end else begin
              r_cnt   <= 6'(MUL_LATENCY - 2);
              r_state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (i_cancel) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 6'd0) begin
            r_hi    <= w_mul_res[63:32];
            r_lo    <= w_mul_res[31:0];
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        S_DIV: begin
          if (i_cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_next;
            r_quo <= {r_quo[30:0], w_q_bit};
            if (r_cnt == 6'd0) r_state <= S_DIV_FIX;
            else r_cnt <= r_cnt - 6'd1;
          end
        end
        S_DIV_FIX: begin
          if (i_cancel) begin
            r_state <= S_IDLE;
          end else begin
            if (r_dvs == 32'd0) begin
              r_hi <= r_a;
              r_lo <= 32'hFFFF_FFFF;
            end else begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed bench for hilo_muldiv_sequencer: multiply class, divide, stall/cancel/reset scenarios.
module tb_hilo_muldiv_sequencer;

  localparam int MUL_LATENCY = 4;
  localparam int DIV_BUSY    = 34;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_BUSY  = 2;
`else
  localparam int EARLY_BUSY  = 34;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [63:0] hilo_in;
  logic        read_hilo;
  logic        cancel;
  logic        busy;
  logic        stall_req;
  logic        hilo_write;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_muldiv_sequencer #(.MUL_LATENCY(MUL_LATENCY), .DIV_BITS(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_op_a(op_a), .i_op_b(op_b),
    .i_hilo_in(hilo_in), .i_read_hilo(read_hilo), .i_cancel(cancel),
    .o_busy(busy), .o_stall_req(stall_req), .o_hilo_write(hilo_write),
    .o_hi_out(hi_out), .o_lo_out(lo_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and runs it to completion, recording busy length, write pulses and written result.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] hl, output int nbusy, output int nwr,
                       output logic [31:0] hi, output logic [31:0] lo);
    start = 1'b1; op = o; op_a = a; op_b = b; hilo_in = hl;
    step();
    start = 1'b0;
    nbusy = 0; nwr = 0; hi = '0; lo = '0;
    while (busy && nbusy < 200) begin
      if (hilo_write) begin
        nwr++;
        hi = hi_out;
        lo = lo_out;
      end
      nbusy++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 3'd0; op_a = 32'd5; op_b = 32'd5;
    hilo_in = '0; read_hilo = 1'b1; cancel = 1'b0;
    step(); step();
    start = 1'b0; read_hilo = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_req); end
    checks++; if (hilo_write !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", hilo_write); end
    checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi_out); end
    checks++; if (lo_out !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo_out); end
  endtask

  task automatic test_mult();
    int nb, nw;
    logic [31:0] hi, lo;
    do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 64'd0, nb, nw, hi, lo);
    checks++; if (nb !== MUL_LATENCY) begin errors++; $display("FAIL mult_busy got %0d want %0d", nb, MUL_LATENCY); end
    checks++; if (nw !== 1) begin errors++; $display("FAIL mult_writes got %0d want 1", nw); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", lo); end
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 64'd0, nb, nw, hi, lo);
    checks++; if (hi !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi got %h want 00000002", hi); end
    checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo got %h want fffffffa", lo); end
    step();
    checks++; if (hi_out !== 32'h0000_0002) begin errors++; $display("FAIL multu_hold got %h want 00000002", hi_out); end
  endtask

  task automatic test_div();
    int nb, nw;
    logic [31:0] hi, lo;
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, nb, nw, hi, lo);
    checks++; if (nb !== DIV_BUSY) begin errors++; $display("FAIL div_busy got %0d want %0d", nb, DIV_BUSY); end
    checks++; if (nw !== 1) begin errors++; $display("FAIL div_writes got %0d want 1", nw); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
    do_op(3'd3, 32'd100, 32'd7, 64'd0, nb, nw, hi, lo);
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h want 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %h want 00000002", hi); end
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, nb, nw, hi, lo);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want 00000000", hi); end
  endtask

  task automatic test_madd_msub();
    int nb, nw;
    logic [31:0] hi, lo;
    do_op(3'd4, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, nb, nw, hi, lo);
    checks++; if (nb !== MUL_LATENCY) begin errors++; $display("FAIL madd_busy got %0d want %0d", nb, MUL_LATENCY); end
    checks++; if ({hi, lo} !== 64'h0000_0002_0000_0000) begin errors++; $display("FAIL madd_res got %h want 0000000200000000", {hi, lo}); end
    do_op(3'd5, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, nb, nw, hi, lo);
    checks++; if (nw !== 1) begin errors++; $display("FAIL msub_writes got %0d want 1", nw); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL msub_res got %h want 0000000000000000", {hi, lo}); end
  endtask

  // DIV in flight; MULT and MFHI arrive at cycle 5 and must be held until the divide retires.
  task automatic test_back_to_back();
    int cyc, first_wr, second_wr, accept_cyc, bad_stall;
    logic [31:0] hi2, lo2;
    first_wr = -1; second_wr = -1; accept_cyc = -1; bad_stall = 0;
    hi2 = '0; lo2 = '0;
    start = 1'b1; op = 3'd2; op_a = 32'd100; op_b = 32'd7;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 150 && second_wr < 0) begin
      if (hilo_write) begin
        if (first_wr < 0) first_wr = cyc;
        else begin second_wr = cyc; hi2 = hi_out; lo2 = lo_out; end
      end
      if (cyc > 5 && (first_wr < 0 || first_wr == cyc) && !stall_req) bad_stall++;
      if (cyc == 5) begin
        start = 1'b1; op = 3'd0; op_a = 32'hFFFF_FFFE; op_b = 32'd3; read_hilo = 1'b1;
      end
      if (cyc > 5 && start && !busy && accept_cyc < 0) accept_cyc = cyc;
      step();
      cyc++;
      if (accept_cyc >= 0 && start) begin start = 1'b0; read_hilo = 1'b0; end
    end
    start = 1'b0; read_hilo = 1'b0;
    checks++; if (first_wr !== DIV_BUSY) begin errors++; $display("FAIL b2b_first_write got %0d want %0d", first_wr, DIV_BUSY); end
    checks++; if (bad_stall !== 0) begin errors++; $display("FAIL b2b_stall_gaps got %0d want 0", bad_stall); end
    checks++; if (accept_cyc !== DIV_BUSY + 1) begin errors++; $display("FAIL b2b_accept got %0d want %0d", accept_cyc, DIV_BUSY + 1); end
    checks++; if (second_wr !== DIV_BUSY + 1 + MUL_LATENCY) begin errors++; $display("FAIL b2b_second_write got %0d want %0d", second_wr, DIV_BUSY + 1 + MUL_LATENCY); end
    checks++; if ({hi2, lo2} !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL b2b_mult_res got %h want fffffffffffffffa", {hi2, lo2}); end
    step();
  endtask

  task automatic test_div0_cancel();
    int nb, nw, wr_seen;
    logic [31:0] hi, lo;
    do_op(3'd3, 32'h0000_1234, 32'd0, 64'd0, nb, nw, hi, lo);
    checks++; if (nb !== DIV_BUSY) begin errors++; $display("FAIL div0_busy got %0d want %0d", nb, DIV_BUSY); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got %h want ffffffff", lo); end
    checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL div0_hi got %h want 00001234", hi); end
    start = 1'b1; op = 3'd2; op_a = 32'd100; op_b = 32'd7;
    step();
    start = 1'b0;
    wr_seen = 0;
    for (int c = 1; c < 10; c++) begin
      if (hilo_write) wr_seen++;
      step();
    end
    cancel = 1'b1;
    #1;
    if (hilo_write) wr_seen++;
    step();
    cancel = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_idle got busy %b want 0", busy); end
    for (int c = 0; c < 40; c++) begin
      if (hilo_write) wr_seen++;
      step();
    end
    checks++; if (wr_seen !== 0) begin errors++; $display("FAIL cancel_writes got %0d want 0", wr_seen); end
    checks++; if ({hi_out, lo_out} !== 64'h0000_1234_FFFF_FFFF) begin errors++; $display("FAIL cancel_hold got %h want 00001234ffffffff", {hi_out, lo_out}); end
  endtask

  task automatic test_idle_drops();
    start = 1'b1; cancel = 1'b1; op = 3'd0; op_a = 32'd2; op_b = 32'd2;
    step();
    start = 1'b0; cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_cancel_start got busy %b want 0", busy); end
    start = 1'b1; op = 3'd6;
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL illegal_stall got %b want 0", stall_req); end
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_div();
    start = 1'b1; op = 3'd3; op_a = 32'd50; op_b = 32'd3;
    step();
    start = 1'b0;
    for (int c = 0; c < 10; c++) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy got %b want 1", busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (hilo_write !== 1'b0) begin errors++; $display("FAIL rstmid_write got %b want 0", hilo_write); end
    checks++; if ({hi_out, lo_out} !== 64'h0) begin errors++; $display("FAIL rstmid_hilo got %h want 0", {hi_out, lo_out}); end
  endtask

  task automatic test_early_out();
    int nb, nw;
    logic [31:0] hi, lo;
    do_op(3'd3, 32'd3, 32'd10, 64'd0, nb, nw, hi, lo);
    checks++; if (nb !== EARLY_BUSY) begin errors++; $display("FAIL early_busy got %0d want %0d", nb, EARLY_BUSY); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL early_lo got %h want 00000000", lo); end
    checks++; if (hi !== 32'd3) begin errors++; $display("FAIL early_hi got %h want 00000003", hi); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_madd_msub();
    test_back_to_back();
    test_div0_cancel();
    test_idle_drops();
    test_reset_mid_div();
    test_early_out();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
